// File: rtl/sc_pkg.sv
// Shared stochastic-computing definitions: widths, LFSR polynomial and SNG state encoding.
package sc_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN   = (1 << WIDTH) - 1;

    // x^8+x^6+x^5+x^4+1 in taps form: feedback from b7, b5, b4, b3
    localparam logic [WIDTH-1:0] LFSR_TAPS    = 8'hB8;
    localparam logic [WIDTH-1:0] DEFAULT_SEED = 8'hB8;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sng_state_t;

    function automatic logic [WIDTH-1:0] step_lfsr(input logic [WIDTH-1:0] s);
        return {s[WIDTH-2:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sc_lfsr.sv
// Maximal-length Fibonacci LFSR with synchronous load; load wins over step.
module sc_lfsr
    import sc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state_out
);

    logic [WIDTH-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = seed_in;
        end else if (step) begin
            lfsr_d = step_lfsr(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_out = lfsr_q;

endmodule

// File: rtl/sc_sng.sv
// Stochastic number generator: emits a 255-bit unipolar stream whose ones-count equals value.
module sc_sng #(
    parameter int unsigned         WIDTH        = sc_pkg::WIDTH,
    parameter logic [WIDTH-1:0]    DEFAULT_SEED = sc_pkg::DEFAULT_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    input  logic [WIDTH-1:0] seed,
    input  logic             hold,
    output logic             sbit,
    output logic             sbit_valid,
    output logic             sbit_last,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] lfsr_dbg
);

    import sc_pkg::*;

    localparam int unsigned      LEN  = (2 ** WIDTH) - 1;
    localparam logic [WIDTH-1:0] LAST = WIDTH'(LEN - 1);

    sng_state_t       state_q, state_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] seed_eff;
    logic             lfsr_load, lfsr_step;

    // A zero seed would lock the LFSR at zero, so substitute a known nonzero one
    assign seed_eff = (seed == '0) ? DEFAULT_SEED : seed;

    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        cnt_d     = cnt_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    value_d   = value;
                    cnt_d     = '0;
                    lfsr_load = 1'b1;
                end
            end
            RUN: begin
                if (!hold) begin
                    if (cnt_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        lfsr_step = 1'b1;
                        cnt_d     = cnt_q + WIDTH'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    sc_lfsr u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load      (lfsr_load),
        .step      (lfsr_step),
        .seed_in   (seed_eff),
        .state_out (lfsr)
    );

    // Each LFSR state 1..LEN appears once, so the comparator yields exactly value_q ones
    assign sbit       = (state_q == RUN) && (value_q >= lfsr);
    assign sbit_valid = (state_q == RUN) && !hold;
    assign sbit_last  = sbit_valid && (cnt_q == LAST);
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign lfsr_dbg   = lfsr;

endmodule
